// File: rtl/term_write_ctrl_pkg.sv
// Shared constants for the text-terminal write controller: screen geometry,
// control character codes, FSM state encoding and a byte classifier.
package term_pkg;

   localparam int unsigned COLS  = 80;
   localparam int unsigned ROWS  = 25;
   localparam int unsigned CELLS = COLS * ROWS;

   localparam logic [7:0] BLANK   = 8'h21;
   localparam logic [7:0] CHAR_BS = 8'h08;
   localparam logic [7:0] CHAR_LF = 8'h0A;
   localparam logic [7:0] CHAR_CR = 8'h0D;

   localparam logic [10:0] LAST_CELL = 11'(CELLS - 1);
   localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
   localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

   // State encoding; CLR_ALL is zero so the reset state is the all-zero code.
   localparam logic [1:0] ST_CLR_ALL  = 2'd0;
   localparam logic [1:0] ST_IDLE     = 2'd1;
   localparam logic [1:0] ST_PUT      = 2'd2;
   localparam logic [1:0] ST_CLR_LINE = 2'd3;

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= 8'h20) && (b <= 8'h7E);
   endfunction

endpackage

// File: rtl/term_write_ctrl_if.sv
// Byte input stream, character RAM write port and cursor/scroll status of
// the terminal write controller, bundled as one interface.
interface term_write_ctrl_if;

   // A byte transfers on a clk100 edge where in_valid && in_ready are both
   // high; in_data must be stable while in_valid is high, in_ready never
   // depends on in_valid, and nothing transfers in any other cycle.
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;

   logic        wr_en;
   logic [10:0] wr_addr;
   logic [7:0]  wr_data;

   logic [4:0]  scroll_row;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;
   logic        busy;
   logic [1:0]  state;

   modport master (
      output in_valid, in_data,
      input  in_ready, wr_en, wr_addr, wr_data,
      input  scroll_row, cursor_col, cursor_row, busy, state
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, wr_en, wr_addr, wr_data,
      output scroll_row, cursor_col, cursor_row, busy, state
   );

endinterface

// File: rtl/term_write_ctrl_addr_map.sv
// Maps a logical (row, col) to a physical cell address given the scroll
// offset: ((row + scroll) mod 25) * 80 + col.
module term_addr_map
   import term_pkg::*;
(
   input  logic [4:0]  row_i,
   input  logic [6:0]  col_i,
   input  logic [4:0]  scroll_i,
   output logic [10:0] addr_o
);

   logic [5:0]  sum;
   logic [4:0]  phys;
   logic [10:0] phys_w;

   // The row sum is reduced mod 25 in 6 bits before widening to 11 bits.
   always_comb begin
      sum = {1'b0, row_i} + {1'b0, scroll_i};
      if (sum >= 6'(ROWS)) begin
         phys = 5'(sum - 6'(ROWS));
      end else begin
         phys = sum[4:0];
      end
      phys_w = {6'd0, phys};
      addr_o = (phys_w * 11'(COLS)) + {4'd0, col_i};
   end

endmodule

// File: rtl/term_write_ctrl.sv
// Text-terminal write controller: turns an ASCII byte stream into writes to
// a 80x25 character index RAM, with cursor handling, scrolling and clears.
module term_write_ctrl
   import term_pkg::*;
(
   input  logic            clk100,
   input  logic            rst,
   term_write_ctrl_if.slave bus
);

   logic [1:0]  state_q, state_d;
   logic [10:0] cnt_q, cnt_d;
   logic [6:0]  col_q, col_d;
   logic [4:0]  row_q, row_d;
   logic [4:0]  scroll_q, scroll_d;
   logic [7:0]  data_q, data_d;

   logic        do_nl;
   logic        wr_active;
   logic [6:0]  map_col;
   logic [10:0] map_addr;

   // CLR_LINE runs with cursor_row at 24 after the scroll has been applied,
   // so logical row 24 maps onto the physical row that was just scrolled out.
   assign map_col = (state_q == ST_CLR_LINE) ? cnt_q[6:0] : col_q;

   term_addr_map u_addr_map (
      .row_i    (row_q),
      .col_i    (map_col),
      .scroll_i (scroll_q),
      .addr_o   (map_addr)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      col_d    = col_q;
      row_d    = row_q;
      scroll_d = scroll_q;
      data_d   = data_q;
      do_nl    = 1'b0;

      case (state_q)
         ST_CLR_ALL: begin
            if (cnt_q == LAST_CELL) begin
               state_d = ST_IDLE;
               cnt_d   = 11'd0;
            end else begin
               cnt_d = cnt_q + 11'd1;
            end
         end
         ST_IDLE: begin
            if (bus.in_valid) begin
               data_d = bus.in_data;
               if (is_printable(bus.in_data)) begin
                  state_d = ST_PUT;
               end else if (bus.in_data == CHAR_LF) begin
                  do_nl = 1'b1;
               end else if (bus.in_data == CHAR_CR) begin
                  col_d = 7'd0;
               end else if ((bus.in_data == CHAR_BS) && (col_q != 7'd0)) begin
                  col_d = col_q - 7'd1;
               end
            end
         end
         ST_PUT: begin
            state_d = ST_IDLE;
            if (col_q == LAST_COL) begin
               col_d = 7'd0;
               do_nl = 1'b1;
            end else begin
               col_d = col_q + 7'd1;
            end
         end
         default: begin
            if (cnt_q[6:0] == LAST_COL) begin
               state_d = ST_IDLE;
               cnt_d   = 11'd0;
            end else begin
               cnt_d = cnt_q + 11'd1;
            end
         end
      endcase

      if (do_nl) begin
         if (row_q != LAST_ROW) begin
            row_d = row_q + 5'd1;
         end else begin
            scroll_d = (scroll_q == LAST_ROW) ? 5'd0 : scroll_q + 5'd1;
            state_d  = ST_CLR_LINE;
            cnt_d    = 11'd0;
         end
      end
   end

   always_ff @(posedge clk100) begin
      if (rst) begin
         state_q  <= ST_CLR_ALL;
         cnt_q    <= 11'd0;
         col_q    <= 7'd0;
         row_q    <= 5'd0;
         scroll_q <= 5'd0;
         data_q   <= 8'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         col_q    <= col_d;
         row_q    <= row_d;
         scroll_q <= scroll_d;
         data_q   <= data_d;
      end
   end

   // Outputs are gated by rst so a reset cycle never carries a write.
   assign wr_active = !rst && (state_q != ST_IDLE);

   assign bus.wr_en      = wr_active;
   assign bus.wr_addr    = !wr_active                ? 11'd0 :
                           (state_q == ST_CLR_ALL)   ? cnt_q : map_addr;
   assign bus.wr_data    = !wr_active                ? 8'd0 :
                           (state_q == ST_PUT)       ? data_q + 8'd1 : BLANK;
   assign bus.in_ready   = !rst && (state_q == ST_IDLE);
   assign bus.busy       = rst || (state_q == ST_CLR_ALL) || (state_q == ST_CLR_LINE);
   assign bus.scroll_row = scroll_q;
   assign bus.cursor_col = col_q;
   assign bus.cursor_row = row_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_term_write_ctrl.sv
// Directed bench for term_write_ctrl: full clear, character writes, control
// codes, line wrap, scrolling with line clears and reset mid-operation.
module tb_term_write_ctrl;
   import term_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   term_write_ctrl_if bus ();

   term_write_ctrl dut (
      .clk100 (clk),
      .rst    (rst),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int last_wr_cyc = 0;
   int ready_cyc   = 0;
   int busy_cyc    = 0;

   logic [10:0] mon_addr_q[$];
   logic [7:0]  mon_data_q[$];
   logic [10:0] exp_q[$];

   // Write-port monitor, sampled away from the active edge.
   always @(negedge clk) begin
      cyc++;
      if (bus.wr_en === 1'b1) begin
         mon_addr_q.push_back(bus.wr_addr);
         mon_data_q.push_back(bus.wr_data);
         last_wr_cyc = cyc;
      end
      if (bus.busy === 1'b1) busy_cyc++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic clear_mon();
      mon_addr_q.delete();
      mon_data_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_wr_en",   bus.wr_en, 0);
      check("rst_wr_addr", bus.wr_addr, 0);
      check("rst_wr_data", bus.wr_data, 0);
      check("rst_ready",   bus.in_ready, 0);
      check("rst_busy",    bus.busy, 1);
      check("rst_col",     bus.cursor_col, 0);
      check("rst_row",     bus.cursor_row, 0);
      check("rst_scroll",  bus.scroll_row, 0);
      check("rst_state",   bus.state, ST_CLR_ALL);
      clear_mon();
      rst = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n = 0;
      @(negedge clk);
      #1;
      while (bus.in_ready !== 1'b1 && n < limit) begin
         @(negedge clk);
         #1;
         n++;
      end
      ready_cyc = cyc;
      check(tag, bus.in_ready, 1);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      #1;
      while (bus.in_ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("send_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic check_clear(input string tag, input int base, input int n);
      int bad = 0;
      int lim;
      check({tag, "_count"}, mon_addr_q.size(), n);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(11'(base + i));
      lim = (mon_addr_q.size() < n) ? mon_addr_q.size() : n;
      for (int i = 0; i < lim; i++) begin
         if (mon_addr_q[i] !== exp_q[i] || mon_data_q[i] !== BLANK) bad++;
      end
      check({tag, "_bad_entries"}, bad, 0);
   endtask

   initial begin
      int bad;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;

      // Power-up clear
      do_reset();
      wait_idle("init_idle", 2100);
      check_clear("clr_all", 0, 2000);
      check("init_ready_next_cycle", ready_cyc - last_wr_cyc, 1);

      // 'A' at row 0 col 0
      clear_mon();
      send_byte(8'h41);
      @(negedge clk);
      #1;
      check("put_ready_low", bus.in_ready, 0);
      check("put_wr_en", bus.wr_en, 1);
      wait_idle("a_idle", 10);
      check("a_count", mon_addr_q.size(), 1);
      check("a_addr", mon_addr_q[0], 0);
      check("a_data", mon_data_q[0], 8'h42);
      check("a_col", bus.cursor_col, 1);

      // BS then 'B' overwrites cell 0
      clear_mon();
      send_byte(CHAR_BS);
      send_byte(8'h42);
      wait_idle("b_idle", 10);
      check("b_count", mon_addr_q.size(), 1);
      check("b_addr", mon_addr_q[0], 0);
      check("b_data", mon_data_q[0], 8'h43);
      check("b_col", bus.cursor_col, 1);

      // Ignored byte, CR, BS at col 0: no writes
      clear_mon();
      send_byte(8'h07);
      wait_idle("ign_idle", 10);
      check("ign_col", bus.cursor_col, 1);
      check("ign_row", bus.cursor_row, 0);
      send_byte(CHAR_CR);
      wait_idle("cr_idle", 10);
      check("cr_col", bus.cursor_col, 0);
      send_byte(CHAR_BS);
      wait_idle("bs0_idle", 10);
      check("bs0_col", bus.cursor_col, 0);
      check("ctrl_no_writes", mon_addr_q.size(), 0);

      // Down to row 3, then a full line of printable bytes
      repeat (3) send_byte(CHAR_LF);
      wait_idle("lf3_idle", 10);
      check("lf3_row", bus.cursor_row, 3);
      check("lf3_col", bus.cursor_col, 0);
      clear_mon();
      for (int i = 0; i < 80; i++) send_byte(8'(8'h20 + i));
      wait_idle("line_idle", 10);
      check("line_count", mon_addr_q.size(), 80);
      bad = 0;
      for (int i = 0; i < 80 && i < mon_addr_q.size(); i++) begin
         if (mon_addr_q[i] !== 11'(240 + i) || mon_data_q[i] !== 8'(8'h21 + i)) bad++;
      end
      check("line_bad_entries", bad, 0);
      check("line_last_addr", mon_addr_q[mon_addr_q.size() - 1], 319);
      check("line_row", bus.cursor_row, 4);
      check("line_col", bus.cursor_col, 0);

      // 25 LF from reset: the 25th scrolls and clears physical row 0
      do_reset();
      wait_idle("init2_idle", 2100);
      repeat (24) send_byte(CHAR_LF);
      wait_idle("lf24_idle", 10);
      check("lf24_row", bus.cursor_row, 24);
      check("lf24_scroll", bus.scroll_row, 0);
      clear_mon();
      busy_cyc = 0;
      send_byte(CHAR_LF);
      wait_idle("scroll1_idle", 200);
      check_clear("scroll1", 0, 80);
      check("scroll1_busy_cycles", busy_cyc, 80);
      check("scroll1_scroll", bus.scroll_row, 1);
      check("scroll1_row", bus.cursor_row, 24);

      // Scroll up to 24, then write at logical row 24 -> physical row 23
      repeat (23) send_byte(CHAR_LF);
      wait_idle("scroll24_idle", 200);
      check("scroll24_scroll", bus.scroll_row, 24);
      check("scroll24_row", bus.cursor_row, 24);
      clear_mon();
      send_byte(8'h5A);
      wait_idle("z_idle", 10);
      check("z_count", mon_addr_q.size(), 1);
      check("z_addr", mon_addr_q[0], 1840);
      check("z_data", mon_data_q[0], 8'h5B);

      // Scroll wraps 24 -> 0 and clears physical row 24
      clear_mon();
      send_byte(CHAR_LF);
      wait_idle("wrap_idle", 200);
      check_clear("wrap", 1920, 80);
      check("wrap_scroll", bus.scroll_row, 0);
      check("wrap_row", bus.cursor_row, 24);

      // Reset during the 40th write of a line clear
      clear_mon();
      send_byte(CHAR_LF);
      repeat (39) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("rst_mid_wr_en", bus.wr_en, 0);
      check("rst_mid_busy", bus.busy, 1);
      check("rst_mid_writes_before", mon_addr_q.size(), 39);
      do_reset();
      wait_idle("restart_idle", 2100);
      check_clear("restart", 0, 2000);
      check("restart_col", bus.cursor_col, 0);
      check("restart_row", bus.cursor_row, 0);
      check("restart_scroll", bus.scroll_row, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
